// File: rtl/control_jugada.sv
// control_jugada: move controller for an 8x8 minesweeper board held in external RAM.
module control_jugada #(
  parameter int N_MINES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       accion,
  input  logic       req,
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic [5:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [8:0] mem_rdata,
  output logic       mem_we,
  output logic [8:0] mem_wdata,
  output logic [3:0] flags_left,
  output logic [6:0] revealed_cnt,
  output logic       game_over,
  output logic       win
);
  typedef enum logic [2:0] {IDLE, RD, EVAL, WR, DONE} state_t;
  localparam logic [6:0] SAFE_CELLS = 7'(64 - N_MINES);
  state_t state;
  logic act, tog_ok, rev_ok, ok;
  logic [8:0] nxt_word;
  logic [6:0] nxt_cnt;
  assign busy = state != IDLE;
  always_comb begin
    tog_ok = !mem_rdata[6] && (mem_rdata[7] || flags_left != 4'd0);
    rev_ok = !mem_rdata[7] && !mem_rdata[6];
    ok = act ? tog_ok : rev_ok;
    nxt_word = act ? mem_rdata ^ 9'h080 : mem_rdata | 9'h040;
    nxt_cnt = revealed_cnt + 7'd1;
  end
  // Counters and sticky flags change on entry to WR so they are visible during the write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      act <= 1'b0;
      ack <= 1'b0;
      err <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_we <= 1'b0;
      mem_wdata <= 9'd0;
      mem_addr <= 6'd0;
      flags_left <= 4'(N_MINES);
      revealed_cnt <= 7'd0;
      game_over <= 1'b0;
      win <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: if (req) begin
          act <= accion;
          mem_addr <= {Y[2:0], X[2:0]};
          if (X > 4'd7 || Y > 4'd7 || game_over || win) begin
            state <= DONE;
            ack <= 1'b1;
            err <= 1'b1;
          end else begin
            state <= RD;
            mem_rd_en <= 1'b1;
          end
        end
        RD: state <= EVAL;
        EVAL: if (ok) begin
          state <= WR;
          mem_we <= 1'b1;
          mem_wdata <= nxt_word;
          if (act) flags_left <= mem_rdata[7] ? flags_left + 4'd1 : flags_left - 4'd1;
          else if (mem_rdata[8]) game_over <= 1'b1;
          else begin
            revealed_cnt <= nxt_cnt;
            if (nxt_cnt == SAFE_CELLS) win <= 1'b1;
          end
        end else begin
          state <= DONE;
          ack <= 1'b1;
          err <= 1'b1;
        end
        WR: begin
          state <= DONE;
          ack <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/control_jugada.md
CONTROL_JUGADA -- requirements
Module: control_jugada

Interface
REQ-001 Parameter N_MINES, default 10: number of mines on the 8x8 board; legal range 1..15.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 X  in  4  column of requested cell; legal 0..7.
REQ-005 Y  in  4  row of requested cell; legal 0..7.
REQ-006 accion  in  1  move type: 0 = reveal, 1 = toggle flag.
REQ-007 req  in  1  move request; held by requester until ack.
REQ-008 ack  out  1  one-cycle move-complete pulse.
REQ-009 err  out  1  move rejected; valid only in the ack cycle, 0 otherwise.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 mem_addr  out  6  board RAM address = {Y[2:0], X[2:0]}.
REQ-012 mem_rd_en  out  1  board RAM read strobe.
REQ-013 mem_rdata  in  9  board RAM read data, valid one cycle after mem_rd_en.
REQ-014 mem_we  out  1  board RAM write strobe.
REQ-015 mem_wdata  out  9  board RAM write data.
REQ-016 flags_left  out  4  flags still available.
REQ-017 revealed_cnt  out  7  safe cells revealed, 0..64.
REQ-018 game_over  out  1  sticky: mine revealed.
REQ-019 win  out  1  sticky: all safe cells revealed.

Function
REQ-020 Cell format SHALL be: bit8 mine, bit7 flag, bit6 revealed, bits5:4 reserved (pass through unchanged), bits3:0 adjacent-mine count (pass through unchanged).
REQ-021 FSM states SHALL be IDLE, RD, EVAL, WR, DONE.
REQ-022 IDLE with req=1 SHALL latch X, Y and accion, then go to RD; req in any other state SHALL be ignored.
REQ-023 If latched X>7 or Y>7, or game_over=1, or win=1, IDLE SHALL go directly to DONE with err=1 and no memory access.
REQ-024 RD SHALL drive mem_rd_en=1 with mem_addr for one cycle, then go to EVAL.
REQ-025 EVAL SHALL capture mem_rdata and go to WR if a write is required, otherwise to DONE with err=1.
REQ-026 WR SHALL drive mem_we=1 for one cycle with mem_wdata = captured word with only the affected bit changed, update counters/flags, then go to DONE.
REQ-027 DONE SHALL assert ack for one cycle and return to IDLE.
REQ-028 Latency, with req sampled in IDLE at cycle n: ack at n+4 with a write, n+3 when rejected in EVAL, n+1 when rejected in IDLE.
REQ-029 mem_addr SHALL hold the latched address in RD, EVAL and WR; mem_rd_en and mem_we SHALL never be high together.
REQ-030 Toggle on a revealed cell SHALL be rejected.
REQ-031 Toggle on a flagged cell SHALL clear bit7 and increment flags_left.
REQ-032 Toggle on an unflagged cell with flags_left=0 SHALL be rejected; otherwise it SHALL set bit7 and decrement flags_left.
REQ-033 Reveal on a flagged or already revealed cell SHALL be rejected.
REQ-034 Reveal on a mine cell SHALL set bit6 and set game_over in WR; revealed_cnt SHALL be unchanged.
REQ-035 Reveal on a safe cell SHALL set bit6 and increment revealed_cnt; when the new count equals 64-N_MINES, win SHALL be set in the same cycle.
REQ-036 The requester SHALL drop req in the ack cycle; if req is still high in IDLE afterwards, a new move SHALL start.

Reset
REQ-037 rst=1 SHALL force state IDLE, ack=0, err=0, busy=0, mem_rd_en=0, mem_we=0, mem_wdata=0, mem_addr=0, flags_left=N_MINES, revealed_cnt=0, game_over=0, win=0.
REQ-038 rst during any state SHALL abort the move with no write and no ack; rst has priority over every transition.

Verification
REQ-039 After reset, flag toggle at (2,3) on cell 0x000 -> mem_we at n+3, addr 26, wdata 0x080, ack at n+4, flags_left 9.
REQ-040 Reveal at (0,0) on cell 0x003 -> wdata 0x043, revealed_cnt 1; second reveal of same cell -> err=1, ack at n+3, no mem_we.
REQ-041 Reveal on cell 0x100 -> wdata 0x140, game_over=1; next request -> ack at n+1 with err=1, no RAM access.
REQ-042 Place 10 flags, then toggle an 11th unflagged cell -> err=1, flags_left stays 0; unflag one -> flags_left 1.
REQ-043 Reveal 54 distinct safe cells -> win=1 in the WR cycle of the 54th; X=8 request -> ack at n+1, err=1.
REQ-044 Assert rst during WR of a flag move -> mem_we=0, no ack, all outputs at reset values next cycle.
